// File: rtl/subsys_sched.sv
// Top-level PocketLed scheduler: key-driven menu selects a subsystem, launches it,
// routes its LED bus to the board and ends the run on done, abort or watchdog.
module subsys_sched #(
  parameter int N_SUB     = 4,
  parameter int LED_W     = 16,
  parameter int TMO_CYC   = 1000000,
  parameter int DRAIN_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [6:0]                 keys,
  input  logic [N_SUB-1:0]           en_back,
  input  logic [N_SUB*LED_W-1:0]     led_in,
  output logic [N_SUB-1:0]           en_sub,
  output logic [LED_W-1:0]           led,
  output logic [$clog2(N_SUB)-1:0]   sel,
  output logic                       busy,
  output logic                       tmo_err
);

  localparam int SEL_W = $clog2(N_SUB);
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam int PH_W  = $clog2(DRAIN_CYC + 2);

  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TMO_CYC);
  localparam logic [PH_W-1:0]  LAUNCH_LST = PH_W'(1);
  localparam logic [PH_W-1:0]  DRAIN_LST  = PH_W'(DRAIN_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_SUB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [PH_W-1:0]    r_phase;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tmo_err;
  logic               w_tmo_set;
  logic               w_tmo_clr;
  logic [N_SUB-1:0]   r_en_sub;
  logic [LED_W-1:0]   r_led;

  logic [2:0]         r_key_s1;
  logic [2:0]         r_key_s2;
  logic [2:0]         r_key_d;
  logic [N_SUB-1:0]   r_eb_s1;
  logic [N_SUB-1:0]   r_eb_s2;
  logic [2:0]         w_key_evt;
  logic               w_abort;
  logic               w_next;
  logic               w_start;
  logic               w_unused_keys;

  logic [LED_W-1:0]   w_led_arr [N_SUB];
  logic [LED_W-1:0]   w_led_sel;
  logic [LED_W-1:0]   w_menu_led;

  assign w_unused_keys = ^keys[6:3];

  for (genvar gi = 0; gi < N_SUB; gi++) begin : g_led_slice
    assign w_led_arr[gi] = led_in[gi*LED_W +: LED_W];
  end

  assign w_led_sel  = w_led_arr[r_sel];
  assign w_menu_led = LED_W'(1) << w_sel_nxt;

  // Two-flop synchronisers plus one delay flop for key rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1 <= '0;
      r_key_s2 <= '0;
      r_key_d  <= '0;
      r_eb_s1  <= '0;
      r_eb_s2  <= '0;
    end else begin
      r_key_s1 <= keys[2:0];
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
      r_eb_s1  <= en_back;
      r_eb_s2  <= r_eb_s1;
    end
  end

  assign w_key_evt = r_key_s2 & ~r_key_d;
  assign w_abort   = w_key_evt[0];
  assign w_next    = w_key_evt[1];
  assign w_start   = w_key_evt[2];

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_tmo_set   = 1'b0;
    w_tmo_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_LAUNCH;
          w_tmo_clr   = 1'b1;
        end else if (w_next) begin
          w_sel_nxt = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
        end
      end
      S_LAUNCH: begin
        if (r_phase == LAUNCH_LST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_DRAIN;
        end else if (r_eb_s2[r_sel]) begin
          w_state_nxt = S_DRAIN;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = S_DRAIN;
          w_tmo_set   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_phase == DRAIN_LST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_phase   <= '0;
      r_cnt     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      if (w_state_nxt != r_state) begin
        r_phase <= '0;
      end else if (r_phase != '1) begin
        r_phase <= r_phase + 1'b1;
      end
      if (w_state_nxt == S_LAUNCH && r_state != S_LAUNCH) begin
        r_cnt <= '0;
      end else if (r_state == S_RUN && r_cnt != TMO_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_tmo_clr) begin
        r_tmo_err <= 1'b0;
      end else if (w_tmo_set) begin
        r_tmo_err <= 1'b1;
      end
    end
  end

  // Outputs registered from next state so enables and LEDs change on the transition edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_sub <= '1;
      r_led    <= '0;
    end else begin
      if (w_state_nxt == S_LAUNCH || w_state_nxt == S_RUN) begin
        r_en_sub <= ~(N_SUB'(1) << r_sel);
      end else begin
        r_en_sub <= '1;
      end
      if (w_state_nxt == S_IDLE) begin
        r_led <= w_menu_led;
      end else if (r_state == S_RUN) begin
        r_led <= w_led_sel;
      end
    end
  end

  assign en_sub  = r_en_sub;
  assign led     = r_led;
  assign sel     = r_sel;
  assign busy    = (r_state != S_IDLE);
  assign tmo_err = r_tmo_err;

endmodule

// File: tb/tb_subsys_sched.sv
// Directed bench for subsys_sched: menu stepping, normal run, stale done flag,
// watchdog timeout, abort/done collision, abort in idle and async reset mid-run.
module tb_subsys_sched;
  localparam int N_SUB     = 4;
  localparam int LED_W     = 16;
  localparam int TMO_CYC   = 50;
  localparam int DRAIN_CYC = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [6:0]             keys;
  logic [N_SUB-1:0]       en_back;
  logic [N_SUB*LED_W-1:0] led_in;
  logic [N_SUB-1:0]       en_sub;
  logic [LED_W-1:0]       led;
  logic [1:0]             sel;
  logic                   busy;
  logic                   tmo_err;

  int n_checks = 0;
  int n_errors = 0;

  subsys_sched #(
    .N_SUB(N_SUB), .LED_W(LED_W), .TMO_CYC(TMO_CYC), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .en_back(en_back), .led_in(led_in),
    .en_sub(en_sub), .led(led), .sel(sel), .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    keys[k] = 1'b1;
    tick(3);
    keys[k] = 1'b0;
    tick(3);
  endtask

  initial begin
    int n;
    logic [1:0] exp_sel;
    keys    = '0;
    en_back = '0;
    led_in  = {16'hD00D, 16'hC0C0, 16'hB0B0, 16'h0010};
    rst_n   = 1'b0;
    tick(2);
    check_val("rst_led", led, 0);
    check_val("rst_en_sub", en_sub, 4'hF);
    check_val("rst_sel", sel, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_tmo", tmo_err, 0);
    rst_n = 1'b1;
    tick(1);
    check_val("idle_led0", led, 16'h0001);

    // menu stepping with wrap
    for (int i = 0; i < 5; i++) begin
      press(1);
      exp_sel = 2'((i + 1) % 4);
      check_val("next_sel", sel, exp_sel);
      check_val("next_en_sub", en_sub, 4'hF);
    end
    check_val("next_led", led, 16'h0002);

    // normal run on subsystem 0 ended by en_back
    press(1); press(1); press(1);
    check_val("t2_sel", sel, 0);
    check_val("t2_led_menu", led, 16'h0001);
    keys[2] = 1'b1;
    tick(3);
    check_val("t2_launch_en", en_sub, 4'hE);
    check_val("t2_launch_busy", busy, 1);
    keys[2] = 1'b0;
    tick(2);
    check_val("t2_run0_led", led, 16'h0001);
    tick(1);
    check_val("t2_run1_led", led, 16'h0010);
    tick(19);
    check_val("t2_run20_en", en_sub, 4'hE);
    en_back[0] = 1'b1;
    tick(2);
    check_val("t2_sync_en", en_sub, 4'hE);
    tick(1);
    check_val("t2_drain_en", en_sub, 4'hF);
    check_val("t2_drain_busy", busy, 1);
    check_val("t2_drain_led", led, 16'h0010);
    led_in[15:0] = 16'h0020;
    tick(3);
    check_val("t2_drain3_busy", busy, 1);
    check_val("t2_drain3_led", led, 16'h0010);
    tick(1);
    check_val("t2_idle_busy", busy, 0);
    check_val("t2_idle_led", led, 16'h0001);
    check_val("t2_tmo", tmo_err, 0);
    en_back[0] = 1'b0;
    led_in[15:0] = 16'h0010;

    // stale done flag held before start on subsystem 1
    press(1);
    check_val("t3_sel", sel, 1);
    en_back[1] = 1'b1;
    tick(3);
    check_val("t3_idle_busy", busy, 0);
    keys[2] = 1'b1;
    tick(3);
    check_val("t3_l0_en", en_sub, 4'hD);
    keys[2] = 1'b0;
    tick(1);
    check_val("t3_l1_en", en_sub, 4'hD);
    tick(1);
    check_val("t3_run_en", en_sub, 4'hD);
    tick(1);
    check_val("t3_drain_en", en_sub, 4'hF);
    check_val("t3_drain_busy", busy, 1);
    tick(3);
    check_val("t3_drain3_busy", busy, 1);
    tick(1);
    check_val("t3_idle_busy", busy, 0);
    en_back[1] = 1'b0;
    tick(3);

    // watchdog timeout: 2 launch + 50 run cycles with enable low
    keys[2] = 1'b1;
    tick(3);
    check_val("t4_launch_en", en_sub, 4'hD);
    keys[2] = 1'b0;
    n = 1;
    while (n < 200) begin
      tick(1);
      if (en_sub == 4'hF) break;
      n++;
    end
    check_val("t4_enable_cycles", n, 52);
    check_val("t4_tmo_set", tmo_err, 1);
    check_val("t4_drain_busy", busy, 1);
    tick(3);
    check_val("t4_drain3_busy", busy, 1);
    tick(1);
    check_val("t4_idle_busy", busy, 0);
    check_val("t4_tmo_sticky", tmo_err, 1);

    // next+start together: start wins, tmo_err clears, then abort collides with done
    keys[2] = 1'b1;
    keys[1] = 1'b1;
    tick(3);
    check_val("t5_sel_kept", sel, 1);
    check_val("t5_launch_en", en_sub, 4'hD);
    check_val("t5_tmo_clr", tmo_err, 0);
    keys[2] = 1'b0;
    keys[1] = 1'b0;
    tick(7);
    check_val("t5_run_en", en_sub, 4'hD);
    keys[0]    = 1'b1;
    en_back[1] = 1'b1;
    tick(3);
    check_val("t5_drain_en", en_sub, 4'hF);
    check_val("t5_drain_busy", busy, 1);
    check_val("t5_tmo", tmo_err, 0);
    keys[0] = 1'b0;
    tick(3);
    check_val("t5_drain3_busy", busy, 1);
    tick(1);
    check_val("t5_idle_busy", busy, 0);
    tick(4);
    check_val("t5_stay_idle", busy, 0);
    check_val("t5_idle_en", en_sub, 4'hF);
    en_back[1] = 1'b0;

    // abort in idle does nothing
    press(0);
    check_val("t5b_busy", busy, 0);
    check_val("t5b_sel", sel, 1);
    check_val("t5b_led", led, 16'h0002);
    check_val("t5b_en", en_sub, 4'hF);

    // asynchronous reset mid-run
    keys[2] = 1'b1;
    tick(3);
    keys[2] = 1'b0;
    tick(5);
    check_val("t6_run_led", led, 16'hB0B0);
    check_val("t6_run_en", en_sub, 4'hD);
    #3 rst_n = 1'b0;
    #1;
    check_val("t6_async_en", en_sub, 4'hF);
    check_val("t6_async_led", led, 0);
    check_val("t6_async_busy", busy, 0);
    check_val("t6_async_sel", sel, 0);
    #2 rst_n = 1'b1;
    tick(1);
    check_val("t6_post_sel", sel, 0);
    check_val("t6_post_busy", busy, 0);
    check_val("t6_post_led", led, 16'h0001);
    check_val("t6_post_en", en_sub, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
